vga_frame_fetch_ctrl: RTL and testbench

- AXI4 read-address master that fetches one video frame per vertical period from the DDR frame buffer into the VGA line FIFO.
- Sits beside the AXI-to-VGA read-data path in the SYSCLK domain and drives the AR channel.
- Paces bursts by FIFO occupancy and outstanding credit, and realigns to VGA_VS every frame.

---
 rtl/vga_frame_fetch_ctrl_if.sv | 21 ++
 rtl/vga_frame_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_vga_frame_fetch_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_fetch_ctrl_if.sv
// AXI4 read-address channel plus the read-data signals the frame fetcher observes.
interface vga_frame_fetch_ctrl_if;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic        RVALID;
  logic        RLAST;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY, RVALID, RLAST
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY, RVALID, RLAST
  );
endinterface

// File: rtl/vga_frame_fetch_ctrl.sv
// AXI4 read-address master fetching one VGA frame per vertical period into the line FIFO,
// pacing bursts by FIFO occupancy and outstanding credit and realigning to VGA_VS.
module vga_frame_fetch_ctrl #(
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int BURST_LEN   = 16,
  parameter int FIFO_DEPTH  = 1024,
  parameter int FIFO_MARGIN = 16,
  parameter int MAX_OUTS    = 4,
  parameter int ARM_WAIT    = 8
) (
  input  logic                   SYSCLK,
  input  logic                   RST,
  input  logic                   ENABLE,
  input  logic [31:0]            FB_BASE,
  input  logic                   VGA_VS,
  input  logic [9:0]             wr_data_count,
  vga_frame_fetch_ctrl_if.master M_AXI,
  output logic                   busy_o,
  output logic                   frame_err_o
);

  localparam int TOTAL_BURSTS = (H_ACT * V_ACT) / BURST_LEN;
  localparam int BI_W         = $clog2(TOTAL_BURSTS + 1);
  localparam int OB_W         = $clog2(MAX_OUTS + 2);
  localparam int ARM_W        = $clog2(ARM_WAIT + 2);

  localparam logic [BI_W-1:0]  TOTAL_BURSTS_L = BI_W'(TOTAL_BURSTS);
  localparam logic [OB_W-1:0]  MAX_OUTS_L     = OB_W'(MAX_OUTS);
  localparam logic [ARM_W-1:0] ARM_WAIT_L     = ARM_W'(ARM_WAIT);
  localparam logic [11:0]      BURST_L12      = 12'(BURST_LEN);
  localparam logic [11:0]      CREDIT_LIMIT   = 12'(FIFO_DEPTH - FIFO_MARGIN);
  localparam logic [31:0]      ADDR_STEP      = 32'(BURST_LEN * 4);

  typedef enum logic [2:0] {IDLE, WAIT_VS, SYNC, ARM, ISSUE, DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_vs_meta, r_vs_s, r_vs_d;
  logic             w_vs_fall, w_vs_rise;
  logic             r_arvalid, w_arvalid_nxt;
  logic [31:0]      r_araddr, w_araddr_nxt;
  logic [BI_W-1:0]  r_issued, w_issued_nxt;
  logic [OB_W-1:0]  r_outs_bursts, w_outs_bursts_nxt;
  logic [11:0]      r_outs_beats, w_outs_beats_nxt;
  logic [ARM_W-1:0] r_arm_cnt, w_arm_cnt_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             w_hs, w_beat, w_last, w_credit_ok;

  // VGA_VS arrives from the pixel clock domain; r_vs_d holds the previous synchronised level.
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      r_vs_meta <= 1'b1;
      r_vs_s    <= 1'b1;
      r_vs_d    <= 1'b1;
    end else begin
      r_vs_meta <= VGA_VS;
      r_vs_s    <= r_vs_meta;
      r_vs_d    <= r_vs_s;
    end
  end

  assign w_vs_fall = r_vs_d & ~r_vs_s;
  assign w_vs_rise = ~r_vs_d & r_vs_s;

  assign w_hs   = r_arvalid & M_AXI.ARREADY;
  assign w_beat = M_AXI.RVALID & (r_outs_beats != 12'd0);
  assign w_last = M_AXI.RVALID & M_AXI.RLAST & (r_outs_bursts != '0);

  // Credit is judged on next-cycle occupancy so ARVALID can reassert right after a handshake.
  assign w_credit_ok = (({2'b00, wr_data_count} + w_outs_beats_nxt + BURST_L12) <= CREDIT_LIMIT)
                       && (w_outs_bursts_nxt < MAX_OUTS_L);

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_arvalid_nxt     = r_arvalid & ~M_AXI.ARREADY;
    w_araddr_nxt      = w_hs ? (r_araddr + ADDR_STEP) : r_araddr;
    w_issued_nxt      = r_issued + BI_W'(w_hs);
    w_outs_bursts_nxt = r_outs_bursts + OB_W'(w_hs) - OB_W'(w_last);
    w_outs_beats_nxt  = r_outs_beats + (w_hs ? BURST_L12 : 12'd0) - {11'd0, w_beat};
    w_arm_cnt_nxt     = r_arm_cnt;
    w_frame_err_nxt   = 1'b0;
    case (r_state)
      IDLE:    w_state_nxt = WAIT_VS;
      WAIT_VS: if (w_vs_fall) w_state_nxt = SYNC;
      SYNC: begin
        if (w_vs_rise) begin
          if (ENABLE) begin
            w_araddr_nxt      = FB_BASE & 32'hFFFF_FFC0;
            w_issued_nxt      = '0;
            w_outs_bursts_nxt = '0;
            w_outs_beats_nxt  = 12'd0;
            w_arm_cnt_nxt     = ARM_WAIT_L;
            w_state_nxt       = ARM;
          end else begin
            w_state_nxt = WAIT_VS;
          end
        end
      end
      ARM: begin
        if (w_vs_fall) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = DRAIN;
        end else if (r_arm_cnt <= ARM_W'(1)) begin
          w_arm_cnt_nxt = '0;
          w_state_nxt   = ISSUE;
        end else begin
          w_arm_cnt_nxt = r_arm_cnt - ARM_W'(1);
        end
      end
      ISSUE: begin
        // An abort keeps any unaccepted ARVALID alive; DRAIN lets it complete.
        if (w_vs_fall) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = DRAIN;
        end else if (w_issued_nxt == TOTAL_BURSTS_L) begin
          w_state_nxt = DRAIN;
        end else if (!w_arvalid_nxt) begin
          w_arvalid_nxt = w_credit_ok;
        end
      end
      DRAIN: if ((r_outs_bursts == '0) && !r_arvalid) w_state_nxt = WAIT_VS;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      r_arvalid     <= 1'b0;
      r_araddr      <= 32'd0;
      r_issued      <= '0;
      r_outs_bursts <= '0;
      r_outs_beats  <= 12'd0;
      r_arm_cnt     <= '0;
      r_frame_err   <= 1'b0;
    end else begin
      r_arvalid     <= w_arvalid_nxt;
      r_araddr      <= w_araddr_nxt;
      r_issued      <= w_issued_nxt;
      r_outs_bursts <= w_outs_bursts_nxt;
      r_outs_beats  <= w_outs_beats_nxt;
      r_arm_cnt     <= w_arm_cnt_nxt;
      r_frame_err   <= w_frame_err_nxt;
    end
  end

  assign M_AXI.ARADDR  = r_araddr;
  assign M_AXI.ARVALID = r_arvalid;
  assign M_AXI.ARLEN   = 8'(BURST_LEN - 1);
  assign M_AXI.ARSIZE  = 3'b010;
  assign M_AXI.ARBURST = 2'b01;

  assign busy_o      = (r_state == ARM) || (r_state == ISSUE) || (r_state == DRAIN);
  assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_vga_frame_fetch_ctrl.sv
// Bench for vga_frame_fetch_ctrl on a 32x4 frame (8 bursts of 16 beats) with a
// behavioural AXI read slave, randomized ready/occupancy/base and directed corner cases.
module tb_vga_frame_fetch_ctrl;
  localparam int H_ACT       = 32;
  localparam int V_ACT       = 4;
  localparam int BURST_LEN   = 16;
  localparam int FIFO_DEPTH  = 1024;
  localparam int FIFO_MARGIN = 16;
  localparam int MAX_OUTS    = 4;
  localparam int ARM_WAIT    = 8;
  localparam int NBURSTS     = H_ACT * V_ACT / BURST_LEN;

  logic        SYSCLK = 1'b0;
  logic        RST;
  logic        ENABLE;
  logic [31:0] FB_BASE;
  logic        VGA_VS;
  logic [9:0]  wrCount;
  logic        busy;
  logic        frameErr;

  vga_frame_fetch_ctrl_if bus();

  vga_frame_fetch_ctrl #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_MARGIN(FIFO_MARGIN), .MAX_OUTS(MAX_OUTS), .ARM_WAIT(ARM_WAIT)
  ) dut (
    .SYSCLK(SYSCLK), .RST(RST), .ENABLE(ENABLE), .FB_BASE(FB_BASE), .VGA_VS(VGA_VS),
    .wr_data_count(wrCount), .M_AXI(bus), .busy_o(busy), .frame_err_o(frameErr)
  );

  always #5 SYSCLK = ~SYSCLK;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pendQ[$];
  logic [31:0] hsAddrQ[$];
  int          mOutsBursts = 0;
  int          outsViolations = 0;
  int          attrViolations = 0;
  int          withdrawViolations = 0;
  int          errPulses = 0;
  int          firstHsCyc = -1;
  int          lastRlastCyc = -1;
  int          riseCyc = 0;
  bit          holdPending = 1'b0;
  logic [31:0] holdAddr = 32'd0;
  bit          slaveEn = 1'b1;
  int          slaveDelay = 5;
  int          beatIdx = 0;

  // Monitor: records accepted addresses and tracks outstanding bursts from observed traffic.
  always @(posedge SYSCLK) begin
    if (RST) begin
      mOutsBursts = 0;
      holdPending = 1'b0;
    end else begin
      if (holdPending && (bus.ARVALID !== 1'b1 || bus.ARADDR !== holdAddr)) withdrawViolations++;
      if (bus.ARVALID && bus.ARREADY) begin
        if (mOutsBursts >= MAX_OUTS) outsViolations++;
        if (bus.ARLEN !== 8'd15 || bus.ARSIZE !== 3'b010 || bus.ARBURST !== 2'b01) attrViolations++;
        hsAddrQ.push_back(bus.ARADDR);
        pendQ.push_back(cyc);
        if (firstHsCyc < 0) firstHsCyc = cyc;
        mOutsBursts++;
      end
      if (bus.RVALID && bus.RLAST) begin
        mOutsBursts--;
        lastRlastCyc = cyc;
      end
      holdPending = bus.ARVALID && !bus.ARREADY;
      holdAddr    = bus.ARADDR;
      if (frameErr) errPulses++;
    end
    cyc++;
  end

  // Slave: returns BURST_LEN beats per accepted burst, in order, slaveDelay cycles after acceptance.
  always @(negedge SYSCLK) begin
    bus.RVALID = 1'b0;
    bus.RLAST  = 1'b0;
    if (RST) begin
      pendQ.delete();
      beatIdx = 0;
    end else if (slaveEn && pendQ.size() > 0 && cyc >= pendQ[0] + slaveDelay) begin
      bus.RVALID = 1'b1;
      bus.RLAST  = (beatIdx == BURST_LEN - 1);
      if (beatIdx == BURST_LEN - 1) begin
        beatIdx = 0;
        void'(pendQ.pop_front());
      end else begin
        beatIdx++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic en);
    FB_BASE = base;
    ENABLE  = en;
    hsAddrQ.delete();
    firstHsCyc = -1;
    VGA_VS = 1'b0;
    repeat (10) @(negedge SYSCLK);
    VGA_VS  = 1'b1;
    riseCyc = cyc;
  endtask

  task automatic waitBusyRise();
    for (int i = 0; i < 60 && busy !== 1'b1; i++) @(negedge SYSCLK);
    checkOutput("busy_rise", busy, 1);
  endtask

  task automatic waitBusyFall(input bit rnd, input int budget, output int fallCyc);
    for (int i = 0; i < budget && busy !== 1'b0; i++) begin
      if (rnd) begin
        bus.ARREADY = 1'($urandom_range(0, 1));
        wrCount     = 10'($urandom_range(0, 1010));
      end
      @(negedge SYSCLK);
    end
    fallCyc = cyc;
    if (rnd) begin
      bus.ARREADY = 1'b1;
      wrCount     = 10'd0;
    end
    checkOutput("busy_fall", busy, 0);
  endtask

  // Expected addresses: aligned base plus one burst stride per accepted burst.
  task automatic checkFrame(input string tag, input logic [31:0] base, input int n);
    logic [31:0] expAddr;
    checkOutput({tag, "_count"}, hsAddrQ.size(), n);
    for (int k = 0; k < n && k < hsAddrQ.size(); k++) begin
      expAddr = (base & 32'hFFFF_FFC0) + 32'(k * BURST_LEN * 4);
      checkOutput($sformatf("%s_addr%0d", tag, k), hsAddrQ[k], expAddr);
    end
    hsAddrQ.delete();
  endtask

  initial begin
    int          fallCyc;
    int          stableErr;
    int          busyHigh;
    int          errBase;
    logic [31:0] base;
    logic [31:0] heldAddr;

    RST = 1'b1; ENABLE = 1'b1; FB_BASE = 32'h8000_0040; VGA_VS = 1'b1;
    wrCount = 10'd0; bus.ARREADY = 1'b1;
    repeat (3) @(negedge SYSCLK);
    checkOutput("rst_arvalid", bus.ARVALID, 0);
    checkOutput("rst_araddr", bus.ARADDR, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_err", frameErr, 0);
    RST = 1'b0;
    repeat (5) @(negedge SYSCLK);

    $display("[TB] nominal frame");
    slaveDelay = 5;
    applyStimulus(32'h8000_0040, 1'b1);
    waitBusyRise();
    waitBusyFall(1'b0, 500, fallCyc);
    checkOutput("nominal_arlen", bus.ARLEN, 15);
    checkOutput("nominal_busy_after_rlast", 32'(fallCyc > lastRlastCyc), 1);
    checkOutput("nominal_arm_wait", 32'((firstHsCyc - riseCyc) >= ARM_WAIT), 1);
    checkFrame("nominal", 32'h8000_0040, NBURSTS);

    $display("[TB] disabled frame");
    applyStimulus(32'h5555_0000, 1'b0);
    busyHigh = 0;
    repeat (30) begin
      @(negedge SYSCLK);
      if (busy) busyHigh++;
    end
    checkOutput("disabled_busy", busyHigh, 0);
    checkOutput("disabled_count", hsAddrQ.size(), 0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 3; f++) begin
      base       = $urandom;
      slaveDelay = $urandom_range(1, 12);
      applyStimulus(base, 1'b1);
      waitBusyRise();
      waitBusyFall(1'b1, 3000, fallCyc);
      checkFrame($sformatf("rand%0d", f), base, NBURSTS);
    end

    $display("[TB] stalled read data");
    slaveDelay = 5; slaveEn = 1'b0; bus.ARREADY = 1'b1;
    base = 32'h0000_4000;
    applyStimulus(base, 1'b1);
    waitBusyRise();
    repeat (40) @(negedge SYSCLK);
    checkOutput("stall_count", hsAddrQ.size(), MAX_OUTS);
    checkOutput("stall_arvalid_low", bus.ARVALID, 0);
    checkOutput("stall_model_outs", mOutsBursts, MAX_OUTS);
    slaveEn = 1'b1;
    waitBusyFall(1'b0, 800, fallCyc);
    checkFrame("stall", base, NBURSTS);

    $display("[TB] FIFO occupancy threshold");
    wrCount = 10'd1000;
    base = 32'h0100_0080;
    applyStimulus(base, 1'b1);
    waitBusyRise();
    repeat (30) @(negedge SYSCLK);
    checkOutput("full_no_ar", hsAddrQ.size(), 0);
    checkOutput("full_arvalid_low", bus.ARVALID, 0);
    wrCount = 10'd990;
    @(negedge SYSCLK);
    checkOutput("thresh_arvalid_next", bus.ARVALID, 1);
    wrCount = 10'd0;
    waitBusyFall(1'b0, 800, fallCyc);
    checkFrame("thresh", base, NBURSTS);

    $display("[TB] ARREADY held low");
    bus.ARREADY = 1'b0;
    base = 32'h3000_00C0;
    applyStimulus(base, 1'b1);
    waitBusyRise();
    for (int i = 0; i < 40 && bus.ARVALID !== 1'b1; i++) @(negedge SYSCLK);
    checkOutput("hold_arvalid_up", bus.ARVALID, 1);
    heldAddr  = bus.ARADDR;
    stableErr = 0;
    repeat (20) begin
      @(negedge SYSCLK);
      if (bus.ARVALID !== 1'b1 || bus.ARADDR !== heldAddr) stableErr++;
    end
    checkOutput("hold_stable", stableErr, 0);
    checkOutput("hold_no_hs", hsAddrQ.size(), 0);
    bus.ARREADY = 1'b1;
    @(negedge SYSCLK);
    checkOutput("hold_one_hs", hsAddrQ.size(), 1);
    waitBusyFall(1'b0, 800, fallCyc);
    checkFrame("hold", base, NBURSTS);

    $display("[TB] premature vsync abort");
    slaveEn = 1'b0; bus.ARREADY = 1'b1;
    base = 32'h1234_5678;
    applyStimulus(base, 1'b1);
    waitBusyRise();
    for (int i = 0; i < 100 && hsAddrQ.size() < 3; i++) @(negedge SYSCLK);
    bus.ARREADY = 1'b0;
    checkOutput("abort_three_hs", hsAddrQ.size(), 3);
    checkOutput("abort_pending_valid", bus.ARVALID, 1);
    errBase = errPulses;
    VGA_VS = 1'b0;
    repeat (10) @(negedge SYSCLK);
    VGA_VS = 1'b1;
    repeat (5) @(negedge SYSCLK);
    checkOutput("abort_valid_held", bus.ARVALID, 1);
    checkOutput("abort_err_pulse", errPulses - errBase, 1);
    bus.ARREADY = 1'b1;
    repeat (5) @(negedge SYSCLK);
    checkOutput("abort_arvalid_low", bus.ARVALID, 0);
    slaveEn = 1'b1;
    waitBusyFall(1'b0, 800, fallCyc);
    repeat (20) @(negedge SYSCLK);
    checkFrame("abort", base, 4);
    base = 32'h2000_0100;
    applyStimulus(base, 1'b1);
    waitBusyRise();
    waitBusyFall(1'b0, 800, fallCyc);
    checkFrame("after_abort", base, NBURSTS);

    $display("[TB] asynchronous reset mid-issue");
    bus.ARREADY = 1'b0;
    base = 32'hC000_0000;
    applyStimulus(base, 1'b1);
    waitBusyRise();
    for (int i = 0; i < 40 && bus.ARVALID !== 1'b1; i++) @(negedge SYSCLK);
    checkOutput("rstmid_pending", bus.ARVALID, 1);
    #2 RST = 1'b1;
    #1;
    checkOutput("rstmid_arvalid", bus.ARVALID, 0);
    checkOutput("rstmid_busy", busy, 0);
    @(negedge SYSCLK);
    @(negedge SYSCLK);
    RST = 1'b0;
    bus.ARREADY = 1'b1;
    hsAddrQ.delete();
    repeat (30) @(negedge SYSCLK);
    checkOutput("rstmid_no_ar", hsAddrQ.size(), 0);
    base = 32'hC000_1040;
    applyStimulus(base, 1'b1);
    waitBusyRise();
    waitBusyFall(1'b0, 800, fallCyc);
    checkOutput("rstmid_arm_wait", 32'((firstHsCyc - riseCyc) >= ARM_WAIT), 1);
    checkFrame("rstmid", base, NBURSTS);

    checkOutput("outs_limit", outsViolations, 0);
    checkOutput("ar_attributes", attrViolations, 0);
    checkOutput("ar_no_withdraw", withdrawViolations, 0);
    checkOutput("err_pulse_total", errPulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
